spi_oled_rx: RTL

- SPI receiver for the OLED link: the sink end of the same mode-0, MSB-first, write-only stream that the OLED SPI transmitter drives (spi_clk, mosi, dc, cs_n).
- Oversamples all link pins on the system clock and reassembles bytes, each tagged with its dc bit.
- Delivers tagged bytes through a small FIFO with a valid/ready handshake.
- Used as an on-chip loopback checker and as the front end of a display model in simulation.

---
 rtl/spi_oled_rx.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_oled_rx.sv
// SPI mode-0 write-only receiver for the OLED link: oversamples the pins, rebuilds dc-tagged bytes and queues them.
// Optional statistics outputs are enabled with `define SPI_OLED_RX_STATS_EN.
module spi_oled_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs_n,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       ovf_clr,
  output logic       overflow,
  output logic       frame_err
`ifdef SPI_OLED_RX_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [15:0] data_count,
  output logic [7:0]  drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] dc_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_q_r;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   dc_s;
  logic                   cs_s;
  logic                   rise_s;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic [7:0] shreg_r;
  logic [7:0] shreg_nxt_s;
  logic       shift_en_s;
  logic       byte_done_s;
  logic       fe_nxt_s;
  logic       frame_err_r;
  logic       push_r;
  logic [8:0] push_data_r;

  logic [8:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] wr_nxt_s;
  logic [AW:0] rd_nxt_s;
  logic        full_s;
  logic        pop_s;
  logic        wr_en_s;
  logic        drop_s;
  logic [8:0]  head_nxt_s;
  logic        valid_nxt_s;
  logic        rx_valid_r;
  logic [7:0]  rx_data_r;
  logic        rx_dc_r;
  logic        overflow_r;

  // pin synchronizers; idle levels are clock low and select high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      dc_sync_r   <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_q_r    <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], spi_dc};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      sclk_q_r    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign dc_s   = dc_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign rise_s = sclk_s & ~sclk_q_r;

  // receive state, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      shreg_r     <= 8'h00;
      frame_err_r <= 1'b0;
      push_r      <= 1'b0;
      push_data_r <= 9'h000;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      shreg_r     <= shreg_nxt_s;
      frame_err_r <= fe_nxt_s;
      push_r      <= byte_done_s;
      if (byte_done_s) begin
        push_data_r <= {dc_s, shreg_r[6:0], mosi_s};
      end else begin
        push_data_r <= push_data_r;
      end
    end
  end

  // a rise coinciding with deselect is ignored because shifting needs cs_s low
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    fe_nxt_s    = 1'b0;
    shift_en_s  = rise_s & ~cs_s;
    byte_done_s = shift_en_s & (cnt_r == 4'd7);
    case (state_r)
      ST_IDLE: begin
        if (!cs_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_nxt_s = ST_IDLE;
          fe_nxt_s    = (cnt_r != 4'd0);
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (cs_s) begin
      cnt_nxt_s   = 4'd0;
      shreg_nxt_s = 8'h00;
    end else if (shift_en_s) begin
      shreg_nxt_s = {shreg_r[6:0], mosi_s};
      if (byte_done_s) begin
        cnt_nxt_s = 4'd0;
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      shreg_nxt_s = shreg_r;
    end
  end

  // FIFO control: next pointers and the next head entry so outputs can be registered
  always_comb begin
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s       = rx_valid_r & rx_ready;
    wr_en_s     = push_r & (~full_s | pop_s);
    drop_s      = push_r & full_s & ~pop_s;
    wr_nxt_s    = wr_ptr_r;
    rd_nxt_s    = rd_ptr_r;
    if (wr_en_s) begin
      wr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    valid_nxt_s = (wr_nxt_s != rd_nxt_s);
    if (wr_en_s && (rd_nxt_s == wr_ptr_r)) begin
      head_nxt_s = push_data_r;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  // FIFO storage, no reset needed because reads are gated by the pointers
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_r;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // pointers, registered show-ahead head and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_dc_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      rx_valid_r <= valid_nxt_s;
      if (valid_nxt_s) begin
        {rx_dc_r, rx_data_r} <= head_nxt_s;
      end else begin
        {rx_dc_r, rx_data_r} <= {rx_dc_r, rx_data_r};
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign rx_valid  = rx_valid_r;
  assign rx_data   = rx_data_r;
  assign rx_dc     = rx_dc_r;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

`ifdef SPI_OLED_RX_STATS_EN
  logic [15:0] cmd_count_r;
  logic [15:0] data_count_r;
  logic [7:0]  drop_count_r;

  // saturating traffic counters; only accepted pushes count as cmd/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_count_r  <= 16'h0000;
      data_count_r <= 16'h0000;
      drop_count_r <= 8'h00;
    end else begin
      if (wr_en_s && !push_data_r[8] && (cmd_count_r != 16'hFFFF)) begin
        cmd_count_r <= cmd_count_r + 16'd1;
      end else begin
        cmd_count_r <= cmd_count_r;
      end
      if (wr_en_s && push_data_r[8] && (data_count_r != 16'hFFFF)) begin
        data_count_r <= data_count_r + 16'd1;
      end else begin
        data_count_r <= data_count_r;
      end
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign cmd_count  = cmd_count_r;
  assign data_count = data_count_r;
  assign drop_count = drop_count_r;
`endif

endmodule
